control_sequencer: RTL and testbench

- Hardwired Moore control unit directly upstream of the CPU datapath.
- Drives every datapath strobe: register in/out enables, PC/IR/Y/Z/HI/LO/MAR/MDR controls, ALU op one-hots and memory Read/Write.
- Sequences fetch, decode and execute for the ALU, multiply/divide, move-from-HI/LO, nop and halt instructions.
- Consumes the IR register contents, which the datapath exports as a port.

---
 rtl/cpu_ctrl_pkg.sv | 113 +++++++++++
 rtl/reg_select_decode.sv | 15 +
 rtl/control_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types, opcode values and IR field positions for the hardwired CPU control unit.
package cpu_ctrl_pkg;

    localparam int unsigned IR_W      = 32;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned NREGS     = 16;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_RST, T0, T1, T2, T3, T4, T5, T6, S_HALT, S_STOP
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'd9;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'd10;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'd11;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd15;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd16;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'd17;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'd18;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'd19;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'd20;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OPC_W-1:0] OP_HALT = 5'd27;

    typedef enum logic [2:0] {
        C_ALU3, C_MULDIV, C_UNARY, C_MOVE, C_NOP, C_HALT, C_UNDEF
    } op_class_t;

    typedef struct packed {
        logic add;
        logic sub;
        logic and_op;
        logic or_op;
        logic ror;
        logic rol;
        logic shl;
        logic shr;
        logic shra;
        logic mul;
        logic div;
        logic neg;
        logic not_op;
    } alu_sel_t;

    typedef struct packed {
        logic     pc_in;
        logic     pc_out;
        logic     inc_pc;
        logic     ir_in;
        logic     mar_in;
        logic     mdr_in;
        logic     mdr_out;
        logic     read;
        logic     write;
        logic     y_in;
        logic     z_in;
        logic     zhigh_out;
        logic     zlow_out;
        logic     hi_in;
        logic     hi_out;
        logic     lo_in;
        logic     lo_out;
        alu_sel_t alu;
    } strobe_t;

    // Groups opcodes by the shape of their execute sequence.
    function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:  return C_ALU3;
            OP_MUL, OP_DIV:           return C_MULDIV;
            OP_NEG, OP_NOT:           return C_UNARY;
            OP_MFHI, OP_MFLO:         return C_MOVE;
            OP_NOP:                   return C_NOP;
            OP_HALT:                  return C_HALT;
            default:                  return C_UNDEF;
        endcase
    endfunction

    function automatic alu_sel_t alu_decode(input logic [OPC_W-1:0] opc);
        alu_sel_t a;
        a = '0;
        case (opc)
            OP_ADD:  a.add    = 1'b1;
            OP_SUB:  a.sub    = 1'b1;
            OP_AND:  a.and_op = 1'b1;
            OP_OR:   a.or_op  = 1'b1;
            OP_ROR:  a.ror    = 1'b1;
            OP_ROL:  a.rol    = 1'b1;
            OP_SHR:  a.shr    = 1'b1;
            OP_SHRA: a.shra   = 1'b1;
            OP_SHL:  a.shl    = 1'b1;
            OP_MUL:  a.mul    = 1'b1;
            OP_DIV:  a.div    = 1'b1;
            OP_NEG:  a.neg    = 1'b1;
            OP_NOT:  a.not_op = 1'b1;
            default: ;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Register index to one-hot select, gated by an enable.
module reg_select_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NREGS-1:0]     onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) onehot_c[idx] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch/decode/execute sequencing for the CPU datapath.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic [IR_W-1:0]  ir,
    input  logic             stop,
    output logic [NREGS-1:0] reg_in,
    output logic [NREGS-1:0] reg_out,
    output logic             PCin,
    output logic             PCout,
    output logic             IncPC,
    output logic             IRin,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             Write,
    output logic             Yin,
    output logic             Zin,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             HIin,
    output logic             HIout,
    output logic             LOin,
    output logic             LOout,
    output logic             ADD,
    output logic             SUB,
    output logic             AND,
    output logic             OR,
    output logic             ROR,
    output logic             ROL,
    output logic             SHL,
    output logic             SHR,
    output logic             SHRA,
    output logic             MUL,
    output logic             DIV,
    output logic             NEG,
    output logic             NOT,
    output logic             run,
    output logic             illegal
);

    state_t                 state;
    state_t                 state_nxt;
    state_t                 t0_entry;
    logic                   illegal_q;
    strobe_t                s;
    logic                   in_en;
    logic                   out_en;
    logic [REG_IDX_W-1:0]   in_idx;
    logic [REG_IDX_W-1:0]   out_idx;
    logic [OPC_W-1:0]       opc;
    logic [REG_IDX_W-1:0]   ra;
    logic [REG_IDX_W-1:0]   rb;
    logic [REG_IDX_W-1:0]   rc;
    op_class_t              cls;
    logic                   undef_c;
    logic                   unused_ir;

    assign opc       = ir[OPC_LSB +: OPC_W];
    assign ra        = ir[RA_LSB +: REG_IDX_W];
    assign rb        = ir[RB_LSB +: REG_IDX_W];
    assign rc        = ir[RC_LSB +: REG_IDX_W];
    assign unused_ir = ^ir[RC_LSB-1:0];
    assign cls       = op_class(opc);
    assign undef_c   = (state == T3) && (cls == C_UNDEF);

    // Instruction boundary: a pending stop parks the sequencer instead of fetching.
    assign t0_entry = stop ? S_STOP : T0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (undef_c) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST: state_nxt = t0_entry;
            T0:    state_nxt = T1;
            T1:    state_nxt = T2;
            T2:    state_nxt = T3;
            T3: begin
                case (cls)
                    C_ALU3, C_MULDIV, C_UNARY: state_nxt = T4;
                    C_MOVE, C_NOP:             state_nxt = t0_entry;
                    default:                   state_nxt = S_HALT;
                endcase
            end
            T4:     state_nxt = (cls == C_UNARY) ? t0_entry : T5;
            T5:     state_nxt = (cls == C_MULDIV) ? T6 : t0_entry;
            T6:     state_nxt = t0_entry;
            S_STOP: state_nxt = stop ? S_STOP : T0;
            default: state_nxt = state;
        endcase
    end

    // Moore strobe decode from state and the latched instruction.
    always_comb begin
        s       = '0;
        in_en   = 1'b0;
        out_en  = 1'b0;
        in_idx  = ra;
        out_idx = rb;
        case (state)
            T0: begin
                s.pc_out = 1'b1;
                s.mar_in = 1'b1;
                s.inc_pc = 1'b1;
                s.z_in   = 1'b1;
            end
            T1: begin
                s.zlow_out = 1'b1;
                s.pc_in    = 1'b1;
                s.read     = 1'b1;
                s.mdr_in   = 1'b1;
            end
            T2: begin
                s.mdr_out = 1'b1;
                s.ir_in   = 1'b1;
            end
            T3: begin
                case (cls)
                    C_ALU3: begin
                        out_en = 1'b1;
                        s.y_in = 1'b1;
                    end
                    C_MULDIV: begin
                        out_en  = 1'b1;
                        out_idx = ra;
                        s.y_in  = 1'b1;
                    end
                    C_UNARY: begin
                        out_en = 1'b1;
                        s.alu  = alu_decode(opc);
                        s.z_in = 1'b1;
                    end
                    C_MOVE: begin
                        s.hi_out = (opc == OP_MFHI);
                        s.lo_out = (opc == OP_MFLO);
                        in_en    = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    C_ALU3: begin
                        out_en  = 1'b1;
                        out_idx = rc;
                        s.alu   = alu_decode(opc);
                        s.z_in  = 1'b1;
                    end
                    C_MULDIV: begin
                        out_en = 1'b1;
                        s.alu  = alu_decode(opc);
                        s.z_in = 1'b1;
                    end
                    C_UNARY: begin
                        s.zlow_out = 1'b1;
                        in_en      = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (cls)
                    C_ALU3: begin
                        s.zlow_out = 1'b1;
                        in_en      = 1'b1;
                    end
                    C_MULDIV: begin
                        s.zlow_out = 1'b1;
                        s.lo_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                s.zhigh_out = 1'b1;
                s.hi_in     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decode u_in_dec (
        .idx      (in_idx),
        .en       (in_en),
        .onehot_c (reg_in)
    );

    reg_select_decode u_out_dec (
        .idx      (out_idx),
        .en       (out_en),
        .onehot_c (reg_out)
    );

    assign PCin     = s.pc_in;
    assign PCout    = s.pc_out;
    assign IncPC    = s.inc_pc;
    assign IRin     = s.ir_in;
    assign MARin    = s.mar_in;
    assign MDRin    = s.mdr_in;
    assign MDRout   = s.mdr_out;
    assign Read     = s.read;
    assign Write    = s.write;
    assign Yin      = s.y_in;
    assign Zin      = s.z_in;
    assign Zhighout = s.zhigh_out;
    assign Zlowout  = s.zlow_out;
    assign HIin     = s.hi_in;
    assign HIout    = s.hi_out;
    assign LOin     = s.lo_in;
    assign LOout    = s.lo_out;
    assign ADD      = s.alu.add;
    assign SUB      = s.alu.sub;
    assign AND      = s.alu.and_op;
    assign OR       = s.alu.or_op;
    assign ROR      = s.alu.ror;
    assign ROL      = s.alu.rol;
    assign SHL      = s.alu.shl;
    assign SHR      = s.alu.shr;
    assign SHRA     = s.alu.shra;
    assign MUL      = s.alu.mul;
    assign DIV      = s.alu.div;
    assign NEG      = s.alu.neg;
    assign NOT      = s.alu.not_op;

    assign run = (state == T0) || (state == T1) || (state == T2) || (state == T3) ||
                 (state == T4) || (state == T5) || (state == T6);

    // Flag is visible in the decode cycle itself, then held by the sticky register.
    assign illegal = illegal_q | undef_c;

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-by-cycle vector table for control_sequencer, compared through an expected-value queue.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        stop;
    logic [31:0] ir;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
    logic Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic ADD, SUB, AND, OR, ROR, ROL, SHL, SHR, SHRA, MUL, DIV, NEG, NOT;
    logic run, illegal;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .reg_in(reg_in), .reg_out(reg_out),
        .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .ROR(ROR), .ROL(ROL),
        .SHL(SHL), .SHR(SHR), .SHRA(SHRA), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT),
        .run(run), .illegal(illegal)
    );

    localparam logic [29:0] K_PCIN   = 30'd1 << 29;
    localparam logic [29:0] K_PCOUT  = 30'd1 << 28;
    localparam logic [29:0] K_INCPC  = 30'd1 << 27;
    localparam logic [29:0] K_IRIN   = 30'd1 << 26;
    localparam logic [29:0] K_MARIN  = 30'd1 << 25;
    localparam logic [29:0] K_MDRIN  = 30'd1 << 24;
    localparam logic [29:0] K_MDROUT = 30'd1 << 23;
    localparam logic [29:0] K_READ   = 30'd1 << 22;
    localparam logic [29:0] K_YIN    = 30'd1 << 20;
    localparam logic [29:0] K_ZIN    = 30'd1 << 19;
    localparam logic [29:0] K_ZHIGH  = 30'd1 << 18;
    localparam logic [29:0] K_ZLOW   = 30'd1 << 17;
    localparam logic [29:0] K_HIIN   = 30'd1 << 16;
    localparam logic [29:0] K_HIOUT  = 30'd1 << 15;
    localparam logic [29:0] K_LOIN   = 30'd1 << 14;
    localparam logic [29:0] K_LOOUT  = 30'd1 << 13;
    localparam logic [29:0] K_ADD    = 30'd1 << 12;
    localparam logic [29:0] K_SUB    = 30'd1 << 11;
    localparam logic [29:0] K_AND    = 30'd1 << 10;
    localparam logic [29:0] K_OR     = 30'd1 << 9;
    localparam logic [29:0] K_ROR    = 30'd1 << 8;
    localparam logic [29:0] K_ROL    = 30'd1 << 7;
    localparam logic [29:0] K_SHL    = 30'd1 << 6;
    localparam logic [29:0] K_SHR    = 30'd1 << 5;
    localparam logic [29:0] K_SHRA   = 30'd1 << 4;
    localparam logic [29:0] K_MUL    = 30'd1 << 3;
    localparam logic [29:0] K_DIV    = 30'd1 << 2;
    localparam logic [29:0] K_NEG    = 30'd1 << 1;
    localparam logic [29:0] K_NOT    = 30'd1 << 0;

    localparam logic [29:0] F0 = K_PCOUT | K_MARIN | K_INCPC | K_ZIN;
    localparam logic [29:0] F1 = K_ZLOW | K_PCIN | K_READ | K_MDRIN;
    localparam logic [29:0] F2 = K_MDROUT | K_IRIN;

    typedef struct {
        logic        clr;
        logic        stop;
        logic [31:0] ir;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [29:0] strb;
        logic        run;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [29:0] strb_act;
    assign strb_act = {PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
                       Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
                       ADD, SUB, AND, OR, ROR, ROL, SHL, SHR, SHRA, MUL, DIV, NEG, NOT};

    function automatic logic [31:0] enc(input int opc, input int ra, input int rb, input int rc);
        logic [31:0] w;
        w        = '0;
        w[31:27] = 5'(opc);
        w[26:23] = 4'(ra);
        w[22:19] = 4'(rb);
        w[18:15] = 4'(rc);
        return w;
    endfunction

    function automatic logic [15:0] oh(input int i);
        return 16'd1 << i;
    endfunction

    task automatic vec(input logic c, input logic s, input logic [31:0] i,
                       input logic [15:0] rin, input logic [15:0] rout,
                       input logic [29:0] strb, input logic r, input logic il);
        vec_t v;
        v.clr = c; v.stop = s; v.ir = i; v.rin = rin; v.rout = rout;
        v.strb = strb; v.run = r; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] i, input logic s);
        vec(1'b0, s, i, 16'h0, 16'h0, F0, 1'b1, 1'b0);
        vec(1'b0, s, i, 16'h0, 16'h0, F1, 1'b1, 1'b0);
        vec(1'b0, s, i, 16'h0, 16'h0, F2, 1'b1, 1'b0);
    endtask

    task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at vector %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    int          ops3 [8];
    logic [29:0] k3   [8];

    initial begin
        vec_t        e;
        logic [31:0] w;
        int          ra, rb, rc, nb, na;

        clr  = 1'b1;
        stop = 1'b0;
        ir   = '0;
        ops3 = '{4, 5, 6, 7, 8, 9, 10, 11};
        k3   = '{K_SUB, K_AND, K_OR, K_ROR, K_ROL, K_SHR, K_SHRA, K_SHL};

        // reset release, then add R5,R2,R4
        w = enc(3, 5, 2, 4);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0000, 16'h0004, K_YIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0000, 16'h0010, K_ADD | K_ZIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0020, 16'h0000, K_ZLOW, 1'b1, 1'b0);
        // mul R3,R1 and div R2,R6
        w = enc(15, 3, 1, 0);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0008, K_YIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0002, K_MUL | K_ZIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0000, K_ZLOW | K_LOIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0000, K_ZHIGH | K_HIIN, 1'b1, 1'b0);
        w = enc(16, 2, 6, 9);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0004, K_YIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0040, K_DIV | K_ZIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0000, K_ZLOW | K_LOIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0000, K_ZHIGH | K_HIIN, 1'b1, 1'b0);
        // remaining three-register ops with varied register fields
        for (int i = 0; i < 8; i++) begin
            ra = i + 8;
            rb = (i * 3 + 1) % 16;
            rc = 15 - i;
            w  = enc(ops3[i], ra, rb, rc);
            fetch(w, 1'b0);
            vec(1'b0, 1'b0, w, 16'h0, oh(rb), K_YIN, 1'b1, 1'b0);
            vec(1'b0, 1'b0, w, 16'h0, oh(rc), k3[i] | K_ZIN, 1'b1, 1'b0);
            vec(1'b0, 1'b0, w, oh(ra), 16'h0, K_ZLOW, 1'b1, 1'b0);
        end
        // neg R10,R11 ; not R0,R15
        w = enc(17, 10, 11, 0);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0800, K_NEG | K_ZIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0400, 16'h0, K_ZLOW, 1'b1, 1'b0);
        w = enc(18, 0, 15, 3);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h8000, K_NOT | K_ZIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0001, 16'h0, K_ZLOW, 1'b1, 1'b0);
        // mfhi R9 ; mflo R1 ; nop
        w = enc(19, 9, 4, 4);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0200, 16'h0, K_HIOUT, 1'b1, 1'b0);
        w = enc(20, 1, 2, 3);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0002, 16'h0, K_LOOUT, 1'b1, 1'b0);
        w = enc(26, 3, 4, 5);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b1, 1'b0);
        // neg R7,R0 with stop held: completes, parks, resumes one cycle after stop drops
        w = enc(17, 7, 0, 0);
        fetch(w, 1'b1);
        vec(1'b0, 1'b1, w, 16'h0, 16'h0001, K_NEG | K_ZIN, 1'b1, 1'b0);
        vec(1'b0, 1'b1, w, 16'h0080, 16'h0, K_ZLOW, 1'b1, 1'b0);
        vec(1'b0, 1'b1, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        // sub R1,R2,R3 aborted by clr at T4
        w = enc(4, 1, 2, 3);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0004, K_YIN, 1'b1, 1'b0);
        vec(1'b1, 1'b0, w, 16'h0, 16'h0008, K_SUB | K_ZIN, 1'b1, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        // halt, stop ignored while halted, then clr
        w = enc(27, 6, 6, 6);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b1, 1'b0);
        vec(1'b0, 1'b1, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        vec(1'b1, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        // undefined opcode 31: sticky illegal, halted until clr
        w = enc(31, 5, 6, 7);
        fetch(w, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b1);
        vec(1'b1, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b1);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, 30'h0, 1'b0, 1'b0);
        vec(1'b0, 1'b0, w, 16'h0, 16'h0, F0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        foreach (vecs[n]) begin
            #1;
            clr  = vecs[n].clr;
            stop = vecs[n].stop;
            ir   = vecs[n].ir;
            exp_q.push_back(vecs[n]);
            @(negedge clk);
            e = exp_q.pop_front();
            check("reg_in",  n, 32'(reg_in),   32'(e.rin));
            check("reg_out", n, 32'(reg_out),  32'(e.rout));
            check("strobes", n, 32'(strb_act), 32'(e.strb));
            check("run",     n, 32'(run),      32'(e.run));
            check("illegal", n, 32'(illegal),  32'(e.ill));
            nb = $countones({reg_out, PCout, MDRout, Zhighout, Zlowout, HIout, LOout});
            na = $countones(strb_act[12:0]);
            checks++;
            if (nb > 1) begin
                errors++;
                $display("FAIL bus_onehot at vector %0d: got %0d drivers expected at most 1", n, nb);
            end
            checks++;
            if (na > 1) begin
                errors++;
                $display("FAIL alu_onehot at vector %0d: got %0d ops expected at most 1", n, na);
            end
            @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
